// File: rtl/instr_decode_stage_pkg.sv
// Shared constants, field positions and types for the instruction decode stage.
package instr_decode_stage_pkg;

  localparam int unsigned DataSizeDef = 16;
  localparam int unsigned ImmSizeDef  = 6;

  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RdMsb     = 11;
  localparam int unsigned RdLsb     = 9;
  localparam int unsigned Rs1Msb    = 8;
  localparam int unsigned Rs1Lsb    = 6;
  localparam int unsigned Rs2Msb    = 5;
  localparam int unsigned Rs2Lsb    = 3;
  localparam int unsigned ImmLsb    = 0;

  localparam logic [3:0] OpAddi = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpBeq  = 4'h7;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } occ_e;

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OpAddi) || (op == OpLw) || (op == OpSw) || (op == OpBeq);
  endfunction

endpackage

// File: rtl/signex6.sv
// Sign-extends the raw immediate field to the datapath width.
module signex6 #(
  parameter int unsigned DATASIZE = 16,
  parameter int unsigned IMMSIZE  = 6
) (
  input  logic [IMMSIZE-1:0]  imm,
  output logic [DATASIZE-1:0] ext
);

  assign ext = {{(DATASIZE - IMMSIZE){imm[IMMSIZE-1]}}, imm};

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: 2-entry skid FIFO of {instr, pc} with combinational field decode of the head.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned DATASIZE = DataSizeDef,
  parameter int unsigned IMMSIZE  = ImmSizeDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATASIZE-1:0] in_instr,
  input  logic [DATASIZE-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_opcode,
  output logic [2:0]          out_rd,
  output logic [2:0]          out_rs1,
  output logic [2:0]          out_rs2,
  output logic [DATASIZE-1:0] out_imm,
  output logic                out_use_imm,
  output logic [DATASIZE-1:0] out_pc
);

  occ_e                state_q, state_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [DATASIZE-1:0] instr_q [2];
  logic [DATASIZE-1:0] pc_q    [2];
  logic                push, pop;
  logic [DATASIZE-1:0] head_instr, head_pc;

  // Handshakes depend on registered state only, so no ready path crosses the stage.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      state_d  = StEmpty;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop)      state_d = StFull;
          else if (pop && !push) state_d = StEmpty;
        end
        StFull:  if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= in_instr;
        pc_q[wr_ptr_q]    <= in_pc;
      end
    end
  end

  // Masking the head word zeroes every decoded field while empty.
  assign head_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign head_pc    = out_valid ? pc_q[rd_ptr_q]    : '0;

  assign out_opcode  = head_instr[OpcodeMsb:OpcodeLsb];
  assign out_rd      = head_instr[RdMsb:RdLsb];
  assign out_rs1     = head_instr[Rs1Msb:Rs1Lsb];
  assign out_rs2     = head_instr[Rs2Msb:Rs2Lsb];
  assign out_use_imm = uses_imm(out_opcode);
  assign out_pc      = head_pc;

  signex6 #(
    .DATASIZE(DATASIZE),
    .IMMSIZE (IMMSIZE)
  ) u_signex6 (
    .imm(head_instr[ImmLsb +: IMMSIZE]),
    .ext(out_imm)
  );

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed-vector bench for instr_decode_stage with hand-computed expectations.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] out_imm;
  logic        out_use_imm;
  logic [15:0] out_pc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(
    .DATASIZE(16),
    .IMMSIZE (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_imm    (out_imm),
    .out_use_imm(out_use_imm),
    .out_pc     (out_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_imm",   32'(out_imm),   32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Decode of an ADDI with negative immediate
    in_valid = 1'b1; in_instr = 16'h4A60; in_pc = 16'h0010; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("dec_valid",   32'(out_valid),   32'd1);
    check("dec_opcode",  32'(out_opcode),  32'd4);
    check("dec_rd",      32'(out_rd),      32'd5);
    check("dec_rs1",     32'(out_rs1),     32'd1);
    check("dec_rs2",     32'(out_rs2),     32'd4);
    check("dec_imm",     32'(out_imm),     32'hFFE0);
    check("dec_use_imm", 32'(out_use_imm), 32'd1);
    check("dec_pc",      32'(out_pc),      32'h0010);
    tick();
    check("pop_empty_valid", 32'(out_valid), 32'd0);
    check("empty_imm_zero",  32'(out_imm),   32'h0);
    check("empty_pc_zero",   32'(out_pc),    32'h0);
    check("empty_op_zero",   32'(out_opcode), 32'h0);

    // Non-immediate opcode
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0298; in_pc = 16'h0020;
    tick();
    in_valid = 1'b0;
    check("nimm_opcode",  32'(out_opcode),  32'd0);
    check("nimm_rd",      32'(out_rd),      32'd1);
    check("nimm_rs1",     32'(out_rs1),     32'd2);
    check("nimm_rs2",     32'(out_rs2),     32'd3);
    check("nimm_imm",     32'(out_imm),     32'h0018);
    check("nimm_use_imm", 32'(out_use_imm), 32'd0);
    out_ready = 1'b1;
    tick();
    check("nimm_drained", 32'(out_valid), 32'd0);

    // Backpressure: fill, hold third offer, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h1111; in_pc = 16'h0100;
    tick();
    check("bp_ready_one", 32'(in_ready), 32'd1);
    check("bp_head1_pc",  32'(out_pc),   32'h0100);
    in_instr = 16'h2222; in_pc = 16'h0102;
    tick();
    check("bp_ready_full", 32'(in_ready), 32'd0);
    in_instr = 16'h3333; in_pc = 16'h0104;
    tick();
    check("bp_held_ready", 32'(in_ready), 32'd0);
    check("bp_held_head",  32'(out_pc),   32'h0100);
    check("bp_held_op",    32'(out_opcode), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_drain2_op", 32'(out_opcode), 32'd2);
    check("bp_drain2_pc", 32'(out_pc),     32'h0102);
    check("bp_drain2_rdy", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_drain3_op", 32'(out_opcode), 32'd3);
    check("bp_drain3_pc", 32'(out_pc),     32'h0104);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop keeps occupancy at ONE
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_instr = 16'hA000 | 16'(i);
      in_pc    = 16'h0200 + 16'(2 * i);
      tick();
      check("pp_valid", 32'(out_valid), 32'd1);
      check("pp_ready", 32'(in_ready),  32'd1);
      check("pp_pc",    32'(out_pc),    32'h0200 + 32'(2 * i));
      check("pp_imm",   32'(out_imm),   32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("pp_empty", 32'(out_valid), 32'd0);

    // Flush while FULL with a same-cycle offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h6001; in_pc = 16'h0400;
    tick();
    in_instr = 16'h6002; in_pc = 16'h0402;
    tick();
    check("fl_full", 32'(in_ready), 32'd0);
    in_instr = 16'h5555; in_pc = 16'h0404; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    tick();
    check("fl_no5555", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = 16'h7123; in_pc = 16'h0500;
    tick();
    in_valid = 1'b0;
    check("fl_after_op",  32'(out_opcode),  32'd7);
    check("fl_after_imm", 32'(out_imm),     32'hFFE3);
    check("fl_after_use", 32'(out_use_imm), 32'd1);
    check("fl_after_pc",  32'(out_pc),      32'h0500);
    out_ready = 1'b1;
    tick();
    check("fl_after_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream with two entries held
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h4A60; in_pc = 16'h0600;
    tick();
    in_instr = 16'h501F; in_pc = 16'h0602;
    tick();
    check("rs_full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_ready", 32'(in_ready),  32'd1);
    check("rs_imm",   32'(out_imm),   32'h0);
    check("rs_pc",    32'(out_pc),    32'h0);
    tick();
    check("rs_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    in_instr = 16'h6005; in_pc = 16'h0700;
    #1;
    check("rs_no_early_accept", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("rs_first_op",  32'(out_opcode),  32'd6);
    check("rs_first_imm", 32'(out_imm),     32'h0005);
    check("rs_first_use", 32'(out_use_imm), 32'd1);
    check("rs_first_pc",  32'(out_pc),      32'h0700);
    // Boundary positive immediate 011111
    in_valid = 1'b1; in_instr = 16'h501F; in_pc = 16'h0702;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("imm_pos_max", 32'(out_imm),    32'h001F);
    check("imm_pos_op",  32'(out_opcode), 32'd5);
    tick();
    check("end_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
